iram_fetch_arbiter: RTL and testbench

Shares the single instruction RAM (`IRAM`) among the cores of the multi-core processor. It sits between the per-core fetch units and the IRAM. Each cycle it round-robin arbitrates pending fetch requests, drives the IRAM address port, and returns the word to the granted core one cycle later, matching the IRAM's registered read. The IRAM is read-only at runtime, so this block never writes.

---
 rtl/iram_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/iram_fetch_arbiter.sv | 63 ++++++
 tb/tb_iram_fetch_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/iram_pkg.sv
// Constants shared by the IRAM image, the control unit and the fetch arbiter.
package iram_pkg;

  localparam int IRAM_AW       = 16;
  localparam int IRAM_DW       = 16;
  localparam int NUM_CORES_DEF = 4;

  typedef logic [IRAM_AW-1:0] iram_addr_t;
  typedef logic [IRAM_DW-1:0] iram_word_t;

  // Opcode values as they appear in the IRAM image.
  localparam iram_word_t ENDOP = iram_word_t'(51);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, search starting
// one past the last granted index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gidx,
  output logic          gany
);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    gany  = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!gany && req[idx]) begin
        gany       = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  // Idle cycles keep the pointer so priority does not drift without grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gany) begin
      ptr <= (gidx == IW'(N-1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/iram_fetch_arbiter.sv
// Shares the read-only IRAM among the cores: round-robin grant, address mux,
// and a one-cycle return path aligned with the IRAM's registered read.
module iram_fetch_arbiter
  import iram_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int AW        = IRAM_AW,
  parameter int DW        = IRAM_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CORES-1:0]    req,
  input  logic [NUM_CORES*AW-1:0] req_addr,
  input  logic [NUM_CORES-1:0]    core_halt,
  output logic [NUM_CORES-1:0]    grant,
  output logic [NUM_CORES-1:0]    rdata_valid,
  output logic [DW-1:0]           rdata,
  output logic [AW-1:0]           iram_addr,
  input  logic [DW-1:0]           iram_rdata
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // Handshake: a core holds req/req_addr until it sees grant in the same
  // cycle; the word comes back on rdata_valid exactly one cycle later and
  // must be taken then, as there is no back-pressure.
  logic [NUM_CORES-1:0] arb_req;
  logic [IW-1:0]        gidx;
  logic                 gany;
  logic [IW-1:0]        gidx_q;
  logic                 gvld_q;

  assign arb_req = rst ? '0 : (req & ~core_halt);

  rr_arbiter #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .req   (arb_req),
    .grant (grant),
    .gidx  (gidx),
    .gany  (gany)
  );

  assign iram_addr = gany ? req_addr[gidx*AW +: AW] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      gvld_q <= 1'b0;
      gidx_q <= '0;
    end else begin
      gvld_q <= gany;
      gidx_q <= gidx;
    end
  end

  // A return still in flight when reset rises is dropped, not delivered.
  assign rdata_valid = (gvld_q && !rst) ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << gidx_q) : '0;
  assign rdata       = iram_rdata;

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Directed bench for iram_fetch_arbiter with an IRAM model and a return-path
// scoreboard fed by the stimulus and drained by an independent monitor.
module tb_iram_fetch_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_addr;
  logic [3:0]  core_halt;
  logic [3:0]  grant;
  logic [3:0]  rdata_valid;
  logic [15:0] rdata;
  logic [15:0] iram_addr;
  logic [15:0] iram_rdata;

  logic [15:0] mem [64];
  logic [19:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  iram_fetch_arbiter #(
    .NUM_CORES (4),
    .AW        (16),
    .DW        (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .core_halt   (core_halt),
    .grant       (grant),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .iram_addr   (iram_addr),
    .iram_rdata  (iram_rdata)
  );

  // clock / IRAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) iram_rdata <= mem[iram_addr[5:0]];

  // driver: drive at negedge, check combinational grant/address, push return
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] hlt,
                      input logic [63:0] addrs, input logic [3:0] eg,
                      input logic [15:0] ea, input bit push, input string name);
    logic [15:0] ea_l;
    @(negedge clk);
    rst       = r;
    req       = rq;
    core_halt = hlt;
    req_addr  = addrs;
    #1;
    n_checks++;
    if (grant !== eg) begin
      n_fail++;
      $display("FAIL %s grant: got %b expected %b", name, grant, eg);
    end
    n_checks++;
    if (iram_addr !== ea) begin
      n_fail++;
      $display("FAIL %s iram_addr: got %0d expected %0d", name, iram_addr, ea);
    end
    ea_l = ea;
    if (push) exp_q.push_back({eg, mem[ea_l[5:0]]});
  endtask

  task automatic idle(input string name);
    step(1'b0, 4'b0000, 4'b0000, 64'd0, 4'b0000, 16'd0, 1'b0, name);
  endtask

  task automatic do_reset();
    idle("pre_reset_idle");
    step(1'b1, 4'b1111, 4'b0000, {16'd3, 16'd2, 16'd1, 16'd0}, 4'b0000, 16'd0, 1'b0, "reset");
    step(1'b1, 4'b1111, 4'b0000, {16'd3, 16'd2, 16'd1, 16'd0}, 4'b0000, 16'd0, 1'b0, "reset");
  endtask

  // scoreboard monitor
  initial begin
    logic [19:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rdata_valid !== 4'b0000) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_return: rdata_valid=%b rdata=%0d expected none", rdata_valid, rdata);
        end else begin
          exp = exp_q.pop_front();
          if ({rdata_valid, rdata} !== exp) begin
            n_fail++;
            $display("FAIL return: rdata_valid=%b rdata=%0d expected %b / %0d",
                     rdata_valid, rdata, exp[19:16], exp[15:0]);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = '0;
    core_halt = '0;
    req_addr  = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]  = 16'd5;
    mem[1]  = 16'd7;
    mem[2]  = 16'd29;
    mem[3]  = 16'd64;
    mem[21] = 16'd62;
    for (int i = 8; i <= 12; i++) mem[i] = 16'd40 + 16'(i - 8);

    do_reset();

    // single request from core 2
    step(1'b0, 4'b0100, 4'b0000, {16'd0, 16'd21, 16'd0, 16'd0}, 4'b0100, 16'd21, 1'b1, "core2_single");
    idle("after_core2");

    // all cores requesting: rotation from core 0
    do_reset();
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'b1111, 4'b0000, {16'd3, 16'd2, 16'd1, 16'd0},
           4'(1 << (i % 4)), 16'(i % 4), 1'b1, "all_rotate");

    // ptr = 2: core 3 wins over core 1
    do_reset();
    step(1'b0, 4'b0010, 4'b0000, {16'd0, 16'd0, 16'd9, 16'd0}, 4'b0010, 16'd9, 1'b1, "ptr_setup");
    step(1'b0, 4'b1010, 4'b0000, {16'd6, 16'd0, 16'd4, 16'd0}, 4'b1000, 16'd6, 1'b1, "ptr2_core3");
    step(1'b0, 4'b0010, 4'b0000, {16'd0, 16'd0, 16'd4, 16'd0}, 4'b0010, 16'd4, 1'b1, "ptr2_core1");

    // halted core is never granted, release grants on the same cycle
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b0, 4'b0001, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd7}, 4'b0000, 16'd0, 1'b0, "halted");
    step(1'b0, 4'b0001, 4'b0000, {16'd0, 16'd0, 16'd0, 16'd7}, 4'b0001, 16'd7, 1'b1, "halt_release");
    step(1'b0, 4'b0011, 4'b0010, {16'd0, 16'd0, 16'd2, 16'd8}, 4'b0001, 16'd8, 1'b1, "halt_skip");

    // reset right after a grant drops the return and clears ptr
    do_reset();
    step(1'b0, 4'b0010, 4'b0000, {16'd0, 16'd0, 16'd3, 16'd0}, 4'b0010, 16'd3, 1'b0, "grant_before_rst");
    step(1'b1, 4'b0010, 4'b0000, {16'd0, 16'd0, 16'd3, 16'd0}, 4'b0000, 16'd0, 1'b0, "rst_after_grant");
    step(1'b0, 4'b1010, 4'b0000, {16'd6, 16'd0, 16'd5, 16'd0}, 4'b0010, 16'd5, 1'b1, "ptr_after_rst");

    // single requester back to back, halt after last grant keeps its return
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'b0010, 4'b0000, {16'd0, 16'd0, 16'(8 + i), 16'd0},
           4'b0010, 16'(8 + i), 1'b1, "core1_stream");
    step(1'b0, 4'b0000, 4'b0010, 64'd0, 4'b0000, 16'd0, 1'b0, "halt_in_flight");
    idle("drain");
    idle("drain");

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_returns: pending=%0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
